// File: rtl/wb_regfile.sv
// MEM/WB write-back register file: 2 combinational read ports, 1 write port, commit counter.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic [DATA_W-1:0] iMemRes,
  input  logic [DATA_W-1:0] iAluRes,
  input  logic [4:0]        iWriteRegister,
  input  logic [4:0]        iReadReg1,
  input  logic [4:0]        iReadReg2,
  output logic [DATA_W-1:0] oReadData1,
  output logic [DATA_W-1:0] oReadData2,
  output logic [DATA_W-1:0] oWbData,
  output logic [15:0]       oWriteCount
);

  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wrInRange;
  logic              commit;

  assign oWbData   = iMemToReg ? iMemRes : iAluRes;
  assign wrInRange = ({1'b0, iWriteRegister} < NREGS_L);
  // Index 0 is hard-wired to zero, so writes to it never commit or count.
  assign commit    = iRegWrite && (iWriteRegister != 5'd0) && wrInRange;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      oWriteCount <= '0;
    end else if (commit) begin
      regs[iWriteRegister] <= oWbData;
      oWriteCount          <= oWriteCount + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (rst_n && (idx != 5'd0) && ({1'b0, idx} < NREGS_L)) begin
      val = regs[idx];
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (idx == iWriteRegister)) begin
        val = oWbData;
      end
`endif
    end
    return val;
  endfunction

  assign oReadData1 = readPort(iReadReg1);
  assign oReadData2 = readPort(iReadReg2);

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width.
REQ-002 Parameter NREGS, default 32, SHALL set the register count; address width is fixed at 5 bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 iRegWrite  input  1  SHALL be the write-back enable from the MEM/WB stage.
REQ-006 iMemToReg  input  1  SHALL select the write-back source: 1 = iMemRes, 0 = iAluRes.
REQ-007 iMemRes  input  DATA_W  SHALL be the load data from MEM/WB.
REQ-008 iAluRes  input  DATA_W  SHALL be the ALU result from MEM/WB.
REQ-009 iWriteRegister  input  5  SHALL be the destination register index.
REQ-010 iReadReg1, iReadReg2  input  5 each  SHALL be the decode-stage source indices.
REQ-011 oReadData1, oReadData2  output  DATA_W each  SHALL be the source operand values.
REQ-012 oWbData  output  DATA_W  SHALL be the selected write-back value, combinational.
REQ-013 oWriteCount  output  16  SHALL count committed writes.

Function
REQ-014 oWbData SHALL equal iMemToReg ? iMemRes : iAluRes every cycle, independent of iRegWrite.
REQ-015 A write SHALL commit on a rising clk when iRegWrite=1 and iWriteRegister!=0; register[iWriteRegister] <= oWbData.
REQ-016 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT increment oWriteCount.
REQ-017 Reads SHALL be combinational: oReadDataN = register[iReadRegN], latency 0.
REQ-018 oWriteCount SHALL increment by 1 per committed write and wrap from 0xFFFF to 0x0000.
REQ-019 Indices >= NREGS SHALL read 0 and SHALL NOT be written.
REQ-020 With iRegWrite=0, no register or counter state SHALL change.
REQ-021 Both read ports addressing the same register SHALL return identical values.

Reset
REQ-022 When rst_n=0, all registers and oWriteCount SHALL clear to 0 immediately, independent of clk.
REQ-023 While rst_n=0, writes SHALL be ignored and reads SHALL return 0.
REQ-024 A write coinciding with reset deassertion SHALL commit only if rst_n is high at that rising edge.
REQ-025 Reset asserted mid-sequence SHALL discard every prior write; no partial state SHALL survive.

Configuration
REQ-026 Macro WB_REGFILE_BYPASS_EN, when defined, SHALL enable write-through: if iRegWrite=1, iWriteRegister!=0 and iReadRegN==iWriteRegister, oReadDataN SHALL equal oWbData in the same cycle.
REQ-027 Without WB_REGFILE_BYPASS_EN, a same-cycle read of the register being written SHALL return the old value; the new value SHALL become visible from the following cycle.
REQ-028 Bypass SHALL never apply to index 0, and SHALL NOT apply while rst_n=0.

Verification
REQ-029 Reset, then read all 32 indices -> all 0, oWriteCount=0.
REQ-030 Write iAluRes=0x1234_5678 to r5 with MemToReg=0, then iMemRes=0xDEAD_BEEF to r6 with MemToReg=1, then read r5/r6 -> 0x12345678 / 0xDEADBEEF, oWriteCount=2.
REQ-031 Write 0xFFFF_FFFF to r0 with iRegWrite=1 -> r0 reads 0, oWriteCount unchanged.
REQ-032 r7=0x11; same cycle write r7=0x22 while iReadReg1=7 -> 0x22 with WB_REGFILE_BYPASS_EN, 0x11 without; next cycle 0x22 in both builds.
REQ-033 Write r3=0xAA, assert rst_n=0 between clock edges -> r3 reads 0 immediately; a write presented during reset is not committed after release.
REQ-034 Perform 65537 writes to r1 -> oWriteCount=1 (wrap), r1 holds the last value.
